window_scan_reader: RTL and testbench
=====================================

Name: window_scan_reader

Overview:
- Read-side partner of the frame-buffer controller.
- While `detect_en` is high, it generates `classifier_rd_addr` to sweep a square window across the stored frame, row-major, at a fixed step.
- It streams each window's pixels to the classifier with first/last framing and waits for a per-window verdict.
- When the whole frame has been scanned, it reports the first hit position and pulses `detect_done`.

Parameters:
- IMG_W, 160, frame width in pixels.
- IMG_H, 120, frame height in pixels.
- WIN, 24, window side in pixels; WIN <= IMG_W and WIN <= IMG_H.
- STEP, 8, window stride, horizontal and vertical.
- DW, 20, pixel data width.
- AW, 15, memory address width; IMG_W*IMG_H <= 2^AW.
- CW, 8, width of the coordinate outputs.
- RD_LAT, 1, memory read latency in cycles.
- STOP_ON_HIT, 0, when 1 the scan ends after the first hit.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- detect_en  in  1  scan enable (level) from the detection state machine.
- rd_addr  out  AW  read address to port A, i.e. `classifier_rd_addr`.
- rd_data  in  DW  memory read data, valid RD_LAT cycles after `rd_addr`.
- pix_data  out  DW  registered pixel to the classifier.
- pix_valid  out  1  `pix_data` valid.
- pix_first  out  1  first pixel of a window, qualified by `pix_valid`.
- pix_last  out  1  last pixel of a window, qualified by `pix_valid`.
- cls_done  in  1  classifier verdict strobe.
- cls_hit  in  1  verdict, sampled with `cls_done`.
- detect_done  out  1  one-cycle scan-complete pulse.
- face_found  out  1  at least one window hit.
- face_x  out  CW  x origin of the first hit window.
- face_y  out  CW  y origin of the first hit window.
- busy  out  1  scan in progress.

Behaviour:
- Reset values: every output is 0; state IDLE; `armed` = 1.
- States:
  - IDLE: `rd_addr` = 0. When `detect_en` is high and `armed` is 1:
    - clear `face_found`, `face_x`, `face_y`;
    - set win_x = win_y = 0, px = py = 0;
    - set `busy` = 1 and go to READ.
  - READ: one address per cycle, rd_addr = (win_y+py)*IMG_W + win_x + px.
    - px increments 0..WIN-1, then wraps to 0 with py+1.
    - After address (WIN-1, WIN-1) go to DRAIN.
    - The multiply may be replaced by an incremental row base; the address sequence must be identical.
  - DRAIN: wait until the window's last pixel has been emitted, then go to WAIT_CLS.
  - WAIT_CLS: hold until `cls_done` = 1.
    - On `cls_done`, if `cls_hit` = 1 and `face_found` = 0: set `face_found` = 1, `face_x` = win_x, `face_y` = win_y. Only the first hit is kept.
    - If STOP_ON_HIT = 1 and this verdict is a hit, go to DONE.
    - Otherwise advance the window:
      - if win_x+STEP <= IMG_W-WIN: win_x += STEP;
      - else win_x = 0 and win_y += STEP;
      - if that new win_y > IMG_H-WIN, go to DONE; otherwise go to READ with px = py = 0.
  - DONE: assert `detect_done` for exactly 1 cycle, set `busy` = 0 and `armed` = 0, return to IDLE.
- Data pipeline:
  - Address valid/first/last flags pass through a delay line matched to RD_LAT.
  - `pix_data` is registered from `rd_data`.
  - `pix_valid` is asserted RD_LAT+1 cycles after the address cycle.
  - `pix_first` marks (0,0); `pix_last` marks (WIN-1, WIN-1).
- Re-arm:
  - `armed` is set whenever `detect_en` is sampled low.
  - If `detect_en` stays high after `detect_done`, the scan must not restart; this covers the controller's one-cycle enable fall lag.
- Abort: if `detect_en` is sampled low in READ, DRAIN or WAIT_CLS:
  - go to IDLE next cycle with `busy` = 0;
  - clear the delay line so no further `pix_valid` is produced;
  - no `detect_done`; result outputs keep their partial values.
- `cls_done` outside WAIT_CLS is ignored.
- Results hold from DONE until the next scan start.
- Degenerate geometry: WIN = IMG_W gives a single window column, WIN = IMG_H a single row; both must terminate correctly.
- Reset mid-operation: every output returns to 0 on the next edge; the delay line is flushed.

Test Plan:
All scenarios use IMG_W=8, IMG_H=6, WIN=4, STEP=2, RD_LAT=1, and memory preloaded with mem[a]=a.
1. Full scan, no hits. Raise `detect_en`; the classifier answers `cls_done` 2 cycles after each `pix_last` with `cls_hit`=0.
   - 6 windows at origins (0,0),(2,0),(4,0),(0,2),(2,2),(4,2).
   - 16 `pix_valid` per window.
   - Window 1 data is 0,1,2,3,8..11,16..19,24..27.
   - Window 6 data is 20..23,28..31,36..39,44..47.
   - One `detect_done` pulse; `face_found`=0.
2. Hits on windows 4 and 6 -> `face_found`=1, `face_x`=0, `face_y`=2 (first hit kept).
3. STOP_ON_HIT=1, hit on window 2 -> `detect_done` after window 2 verdict, exactly 32 `pix_valid`, `face_x`=2, `face_y`=0.
4. Drop `detect_en` during window 3 READ -> `pix_valid` low within 2 cycles, no `detect_done`, `busy`=0. Re-raise `detect_en` -> first address is 0.
5. Hold `detect_en` high 5 cycles after `detect_done` -> `busy` stays 0. Pull it low 1 cycle, then high -> a new scan starts with results cleared.
6. Assert `rst` mid-READ of window 2 -> all outputs 0 next cycle; a later `detect_en` starts at (0,0).

Source files
------------

// File: rtl/window_scan_reader_if.sv
// Bus bundle between the window scan reader, port A of the frame buffer and the classifier.
interface window_scan_reader_if #(
  parameter int unsigned DW = 20,
  parameter int unsigned AW = 15,
  parameter int unsigned CW = 8
);
  logic          detect_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_first;
  logic          pix_last;
  logic          cls_done;
  logic          cls_hit;
  logic          detect_done;
  logic          face_found;
  logic [CW-1:0] face_x;
  logic [CW-1:0] face_y;
  logic          busy;

  // Reader side
  modport master (
    input  detect_en, rd_data, cls_done, cls_hit,
    output rd_addr, pix_data, pix_valid, pix_first, pix_last,
    output detect_done, face_found, face_x, face_y, busy
  );

  // Memory / classifier / controller side
  modport slave (
    output detect_en, rd_data, cls_done, cls_hit,
    input  rd_addr, pix_data, pix_valid, pix_first, pix_last,
    input  detect_done, face_found, face_x, face_y, busy
  );
endinterface

// File: rtl/window_scan_reader.sv
// Sweeps a square window over the stored frame, streams its pixels to the
// classifier and records the first window that the classifier flags.
module window_scan_reader #(
  parameter int unsigned IMG_W       = 160,
  parameter int unsigned IMG_H       = 120,
  parameter int unsigned WIN         = 24,
  parameter int unsigned STEP        = 8,
  parameter int unsigned DW          = 20,
  parameter int unsigned AW          = 15,
  parameter int unsigned CW          = 8,
  parameter int unsigned RD_LAT      = 1,
  parameter bit          STOP_ON_HIT = 1'b0
) (
  input logic                clk,
  input logic                rst,
  window_scan_reader_if.master bus
);

  localparam int unsigned XW       = $clog2(IMG_W + STEP + 1);
  localparam int unsigned YW       = $clog2(IMG_H + STEP + 1);
  localparam int unsigned PW       = $clog2(WIN + 1);
  localparam int unsigned X_LAST   = IMG_W - WIN;
  localparam int unsigned Y_LAST   = IMG_H - WIN;
  localparam int unsigned P_LAST   = WIN - 1;
  localparam int unsigned ROW_STEP = STEP * IMG_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WAIT_CLS,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] win_x_q, win_x_d;
  logic [YW-1:0] win_y_q, win_y_d;
  logic [PW-1:0] px_q, px_d, py_q, py_d;
  logic [AW-1:0] win_row_q, win_row_d;     // win_y * IMG_W
  logic [AW-1:0] row_base_q, row_base_d;   // (win_y + py) * IMG_W + win_x
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          found_q, found_d;
  logic [CW-1:0] fx_q, fx_d, fy_q, fy_d;
  logic          armed_q, armed_d;

  logic          flush_c;
  logic          a_vld_c, a_first_c, a_last_c;
  logic [XW-1:0] win_x_step_c;
  logic [YW-1:0] win_y_step_c;

  logic [RD_LAT:0] vld_sr, fst_sr, lst_sr;
  logic [DW-1:0]   pix_data_q;

  assign win_x_step_c = win_x_q + XW'(STEP);
  assign win_y_step_c = win_y_q + YW'(STEP);
  assign a_vld_c      = (state_q == S_READ);
  assign a_first_c    = (px_q == '0) && (py_q == '0);
  assign a_last_c     = (px_q == PW'(P_LAST)) && (py_q == PW'(P_LAST));

  // State and scan registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      win_x_q    <= '0;
      win_y_q    <= '0;
      px_q       <= '0;
      py_q       <= '0;
      win_row_q  <= '0;
      row_base_q <= '0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      fx_q       <= '0;
      fy_q       <= '0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      win_x_q    <= win_x_d;
      win_y_q    <= win_y_d;
      px_q       <= px_d;
      py_q       <= py_d;
      win_row_q  <= win_row_d;
      row_base_q <= row_base_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      found_q    <= found_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      armed_q    <= armed_d;
    end
  end

  // Next-state, address walk and verdict bookkeeping
  always_comb begin
    state_d    = state_q;
    win_x_d    = win_x_q;
    win_y_d    = win_y_q;
    px_d       = px_q;
    py_d       = py_q;
    win_row_d  = win_row_q;
    row_base_d = row_base_q;
    rd_addr_d  = rd_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    found_d    = found_q;
    fx_d       = fx_q;
    fy_d       = fy_q;
    armed_d    = armed_q;
    flush_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        rd_addr_d = '0;
        if (bus.detect_en && armed_q) begin
          found_d    = 1'b0;
          fx_d       = '0;
          fy_d       = '0;
          win_x_d    = '0;
          win_y_d    = '0;
          px_d       = '0;
          py_d       = '0;
          win_row_d  = '0;
          row_base_d = '0;
          busy_d     = 1'b1;
          state_d    = S_READ;
        end
      end

      S_READ: begin
        if (!bus.detect_en) begin
          flush_c   = 1'b1;
          busy_d    = 1'b0;
          rd_addr_d = '0;
          state_d   = S_IDLE;
        end else if (a_last_c) begin
          state_d = S_DRAIN;
        end else if (px_q == PW'(P_LAST)) begin
          px_d       = '0;
          py_d       = py_q + PW'(1);
          row_base_d = row_base_q + AW'(IMG_W);
          rd_addr_d  = row_base_q + AW'(IMG_W);
        end else begin
          px_d      = px_q + PW'(1);
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end

      S_DRAIN: begin
        if (!bus.detect_en) begin
          flush_c   = 1'b1;
          busy_d    = 1'b0;
          rd_addr_d = '0;
          state_d   = S_IDLE;
        end else if (vld_sr[RD_LAT] && lst_sr[RD_LAT]) begin
          state_d = S_WAIT_CLS;
        end
      end

      S_WAIT_CLS: begin
        if (!bus.detect_en) begin
          flush_c   = 1'b1;
          busy_d    = 1'b0;
          rd_addr_d = '0;
          state_d   = S_IDLE;
        end else if (bus.cls_done) begin
          if (bus.cls_hit && !found_q) begin
            found_d = 1'b1;
            fx_d    = CW'(win_x_q);
            fy_d    = CW'(win_y_q);
          end
          if (STOP_ON_HIT && bus.cls_hit) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            armed_d = 1'b0;
            state_d = S_DONE;
          end else if (win_x_step_c <= XW'(X_LAST)) begin
            win_x_d    = win_x_step_c;
            px_d       = '0;
            py_d       = '0;
            row_base_d = win_row_q + AW'(win_x_step_c);
            rd_addr_d  = win_row_q + AW'(win_x_step_c);
            state_d    = S_READ;
          end else if (win_y_step_c > YW'(Y_LAST)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            armed_d = 1'b0;
            state_d = S_DONE;
          end else begin
            win_x_d    = '0;
            win_y_d    = win_y_step_c;
            px_d       = '0;
            py_d       = '0;
            win_row_d  = win_row_q + AW'(ROW_STEP);
            row_base_d = win_row_q + AW'(ROW_STEP);
            rd_addr_d  = win_row_q + AW'(ROW_STEP);
            state_d    = S_READ;
          end
        end
      end

      S_DONE: begin
        rd_addr_d = '0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A low enable re-arms; this keeps a lagging enable from restarting the scan
    if (!bus.detect_en) begin
      armed_d = 1'b1;
    end
  end

  // Flag delay line matched to memory latency, plus the registered pixel
  always_ff @(posedge clk) begin
    if (rst || flush_c) begin
      vld_sr <= '0;
      fst_sr <= '0;
      lst_sr <= '0;
    end else begin
      vld_sr[0] <= a_vld_c;
      fst_sr[0] <= a_first_c;
      lst_sr[0] <= a_last_c;
      for (int i = 1; i <= int'(RD_LAT); i++) begin
        vld_sr[i] <= vld_sr[i-1];
        fst_sr[i] <= fst_sr[i-1];
        lst_sr[i] <= lst_sr[i-1];
      end
    end
    if (rst) begin
      pix_data_q <= '0;
    end else begin
      pix_data_q <= bus.rd_data;
    end
  end

  assign bus.rd_addr     = rd_addr_q;
  assign bus.pix_data    = pix_data_q;
  assign bus.pix_valid   = vld_sr[RD_LAT];
  assign bus.pix_first   = fst_sr[RD_LAT];
  assign bus.pix_last    = lst_sr[RD_LAT];
  assign bus.detect_done = done_q;
  assign bus.face_found  = found_q;
  assign bus.face_x      = fx_q;
  assign bus.face_y      = fy_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_window_scan_reader.sv
// Bench for window_scan_reader: two instances (run to end / stop on first hit)
// against a frame memory holding mem[a] = a and a scripted classifier.
module tb_window_scan_reader;

  localparam int unsigned IMG_W  = 8;
  localparam int unsigned IMG_H  = 6;
  localparam int unsigned WIN    = 4;
  localparam int unsigned STEP   = 2;
  localparam int unsigned DW     = 20;
  localparam int unsigned AW     = 15;
  localparam int unsigned CW     = 8;
  localparam int unsigned RD_LAT = 1;
  localparam int NX   = (IMG_W - WIN) / STEP + 1;
  localparam int NY   = (IMG_H - WIN) / STEP + 1;
  localparam int NWIN = NX * NY;
  localparam int NPIX = WIN * WIN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus side, written only by the main process
  logic        en_r      [2];
  logic        cls_done_r[2];
  logic        cls_hit_r [2];
  logic [31:0] hit_mask  [2];
  int          pv_cnt    [2];
  int          win_cnt   [2];
  int          pix_idx   [2];
  int          done_cnt  [2];
  int          cls_timer [2];

  // Observed outputs
  logic          busy_w [2];
  logic          done_w [2];
  logic          found_w[2];
  logic          pv_w   [2];
  logic          pf_w   [2];
  logic          pl_w   [2];
  logic [DW-1:0] pix_w  [2];
  logic [CW-1:0] fx_w   [2];
  logic [CW-1:0] fy_w   [2];
  logic [AW-1:0] addr_w [2];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    window_scan_reader_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    window_scan_reader #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .STEP(STEP),
      .DW(DW), .AW(AW), .CW(CW), .RD_LAT(RD_LAT), .STOP_ON_HIT(g == 1)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign bus.detect_en = en_r[g];
    assign bus.cls_done  = cls_done_r[g];
    assign bus.cls_hit   = cls_hit_r[g];
    assign busy_w[g]     = bus.busy;
    assign done_w[g]     = bus.detect_done;
    assign found_w[g]    = bus.face_found;
    assign pv_w[g]       = bus.pix_valid;
    assign pf_w[g]       = bus.pix_first;
    assign pl_w[g]       = bus.pix_last;
    assign pix_w[g]      = bus.pix_data;
    assign fx_w[g]       = bus.face_x;
    assign fy_w[g]       = bus.face_y;
    assign addr_w[g]     = bus.rd_addr;

    // Frame memory with one cycle of read latency, mem[a] = a
    always @(posedge clk) bus.rd_data <= DW'(bus.rd_addr);
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Window w origin in row-major scan order
  function automatic int exp_x(input int w);
    return (w % NX) * int'(STEP);
  endfunction

  function automatic int exp_y(input int w);
    return (w / NX) * int'(STEP);
  endfunction

  function automatic int exp_pix(input int w, input int k);
    return (exp_y(w) + k / int'(WIN)) * int'(IMG_W) + exp_x(w) + k % int'(WIN);
  endfunction

  function automatic int first_hit(input logic [31:0] mask);
    for (int w = 0; w < NWIN; w++) if (mask[w]) return w;
    return -1;
  endfunction

  function automatic logic hit_bit(input int g, input int w);
    if (w < 0 || w > 31) return 1'b0;
    return hit_mask[g][w];
  endfunction

  // One clock: sample at the falling edge, track pixels, play the classifier
  task automatic step();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      cls_done_r[g] = 1'b0;
      if (cls_timer[g] > 0) begin
        cls_timer[g]--;
        if (cls_timer[g] == 0) begin
          cls_done_r[g] = 1'b1;
          cls_hit_r[g]  = hit_bit(g, win_cnt[g] - 1);
        end
      end
      if (done_w[g]) done_cnt[g]++;
      if (pv_w[g]) begin
        check_eq("pix_data", int'(pix_w[g]), exp_pix(win_cnt[g], pix_idx[g]));
        check_eq("pix_first", int'(pf_w[g]), int'(pix_idx[g] == 0));
        check_eq("pix_last", int'(pl_w[g]), int'(pix_idx[g] == NPIX - 1));
        pv_cnt[g]++;
        if (pix_idx[g] == NPIX - 1) begin
          pix_idx[g]   = 0;
          win_cnt[g]++;
          cls_timer[g] = 2;
        end else begin
          pix_idx[g]++;
        end
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts(input int g);
    pv_cnt[g]     = 0;
    win_cnt[g]    = 0;
    pix_idx[g]    = 0;
    done_cnt[g]   = 0;
    cls_timer[g]  = 0;
    cls_done_r[g] = 1'b0;
    cls_hit_r[g]  = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    int start = done_cnt[g];
    for (int i = 0; i < budget && done_cnt[g] == start; i++) step();
    check_eq("done_seen", done_cnt[g] - start, 1);
  endtask

  task automatic wait_pix(input int g, input int n, input int budget);
    for (int i = 0; i < budget && pv_cnt[g] < n; i++) step();
    check_eq("reach_pix", int'(pv_cnt[g] >= n), 1);
  endtask

  task automatic check_idle_outputs(input int g);
    check_eq("busy0",  int'(busy_w[g]),  0);
    check_eq("pv0",    int'(pv_w[g]),    0);
    check_eq("done0",  int'(done_w[g]),  0);
    check_eq("found0", int'(found_w[g]), 0);
    check_eq("fx0",    int'(fx_w[g]),    0);
    check_eq("fy0",    int'(fy_w[g]),    0);
    check_eq("addr0",  int'(addr_w[g]),  0);
  endtask

  initial begin
    int fh;
    int pv_hold;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      en_r[g]     = 1'b0;
      hit_mask[g] = '0;
      clear_counts(g);
    end
    steps(3);
    check_idle_outputs(0);
    check_idle_outputs(1);
    rst = 1'b0;
    step();

    // Full scan, no hits
    en_r[0] = 1'b1;
    wait_done(0, 2000);
    steps(2);
    check_eq("t1_windows", win_cnt[0], NWIN);
    check_eq("t1_pixels",  pv_cnt[0],  NWIN * NPIX);
    check_eq("t1_pulses",  done_cnt[0], 1);
    check_eq("t1_found",   int'(found_w[0]), 0);
    check_eq("t1_busy",    int'(busy_w[0]),  0);

    // Enable held high after completion must not restart
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hold_busy", int'(busy_w[0]), 0);
    end
    check_eq("hold_pixels", pv_cnt[0], NWIN * NPIX);

    // Hits on windows 4 and 6, first kept
    hit_mask[0] = 32'h28;
    clear_counts(0);
    en_r[0] = 1'b0;
    step();
    en_r[0] = 1'b1;
    steps(3);
    check_eq("t2_restart", int'(busy_w[0]), 1);
    wait_done(0, 2000);
    steps(2);
    fh = first_hit(hit_mask[0]);
    check_eq("t2_found",   int'(found_w[0]), 1);
    check_eq("t2_face_x",  int'(fx_w[0]), exp_x(fh));
    check_eq("t2_face_y",  int'(fy_w[0]), exp_y(fh));
    check_eq("t2_windows", win_cnt[0], NWIN);

    // Results cleared by a new scan start
    hit_mask[0] = '0;
    clear_counts(0);
    en_r[0] = 1'b0;
    step();
    en_r[0] = 1'b1;
    steps(3);
    check_eq("t5_found_clr", int'(found_w[0]), 0);
    check_eq("t5_fy_clr",    int'(fy_w[0]), 0);
    wait_done(0, 2000);
    steps(2);
    check_eq("t5_found", int'(found_w[0]), 0);

    // Abort during the third window's read
    en_r[0] = 1'b0;
    step();
    clear_counts(0);
    en_r[0] = 1'b1;
    wait_pix(0, 2 * NPIX + 3, 2000);
    en_r[0] = 1'b0;
    steps(2);
    check_eq("t4_pv_low", int'(pv_w[0]),   0);
    check_eq("t4_busy",   int'(busy_w[0]), 0);
    pv_hold = pv_cnt[0];
    steps(30);
    check_eq("t4_no_pix",  pv_cnt[0],   pv_hold);
    check_eq("t4_no_done", done_cnt[0], 0);
    clear_counts(0);
    en_r[0] = 1'b1;
    step();
    check_eq("t4_busy_up", int'(busy_w[0]), 1);
    check_eq("t4_addr0",   int'(addr_w[0]), 0);
    wait_done(0, 2000);
    steps(2);
    check_eq("t4_windows", win_cnt[0], NWIN);

    // Stop on hit: hit on window 2
    hit_mask[1] = 32'h2;
    clear_counts(1);
    en_r[1] = 1'b1;
    wait_done(1, 2000);
    steps(4);
    fh = first_hit(hit_mask[1]);
    check_eq("t3_pixels",  pv_cnt[1],  (fh + 1) * NPIX);
    check_eq("t3_windows", win_cnt[1], fh + 1);
    check_eq("t3_found",   int'(found_w[1]), 1);
    check_eq("t3_face_x",  int'(fx_w[1]), exp_x(fh));
    check_eq("t3_face_y",  int'(fy_w[1]), exp_y(fh));
    check_eq("t3_pulses",  done_cnt[1], 1);
    en_r[1] = 1'b0;

    // Reset during the second window's read
    en_r[0] = 1'b0;
    step();
    hit_mask[0] = 32'h1;
    clear_counts(0);
    en_r[0] = 1'b1;
    wait_pix(0, NPIX + 4, 2000);
    check_eq("t6_pre_found", int'(found_w[0]), 1);
    rst = 1'b1;
    step();
    check_idle_outputs(0);
    check_eq("t6_first", int'(pf_w[0]), 0);
    check_eq("t6_last",  int'(pl_w[0]), 0);
    en_r[0] = 1'b0;
    step();
    rst = 1'b0;
    step();
    hit_mask[0] = '0;
    clear_counts(0);
    en_r[0] = 1'b1;
    step();
    check_eq("t6_busy_up", int'(busy_w[0]), 1);
    check_eq("t6_addr0",   int'(addr_w[0]), 0);
    wait_done(0, 2000);
    steps(2);
    check_eq("t6_windows", win_cnt[0], NWIN);
    check_eq("t6_found",   int'(found_w[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
